asphalt_debug_ocimem: RTL

- Sysclk-domain consumer of the debug-slave command stream: jdo plus the take_action_ocimem_*/take_no_action_ocimem_a strobes.
- Owns the on-chip debug monitor RAM, the JTAG address/data registers (MonAReg/MonDReg) and the monitor handshake flags.
- Arbitrates single-port RAM access between JTAG commands and the CPU's Avalon debug slave.
- Its MonDReg and monitor_ready/monitor_error outputs feed back into the debug-slave wrapper.

---
 rtl/asphalt_debug_ocimem_pkg.sv | 36 +++
 rtl/asphalt_debug_ocimem_ram.sv | 33 +++
 rtl/asphalt_debug_ocimem.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/asphalt_debug_ocimem_pkg.sv
// Shared constants and types for the on-chip debug monitor memory block.
package asphalt_debug_ocimem_pkg;

  // Field positions inside the 38-bit debug-slave command payload.
  localparam int JDO_W        = 38;
  localparam int JDO_ADDR_LSB = 10;
  localparam int JDO_RSTREQ   = 22;
  localparam int JDO_GO       = 23;
  localparam int JDO_CLRERR   = 24;
  localparam int JDO_DATA_LSB = 3;

  // Bit positions of the CPU-visible control register.
  localparam int CTRL_READY  = 0;
  localparam int CTRL_ERROR  = 1;
  localparam int CTRL_GO     = 2;
  localparam int CTRL_RSTREQ = 3;

  // Avalon slave sequencing.
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } av_state_e;

  // Assemble the control-register read value from the handshake flags.
  function automatic logic [31:0] ctrl_word(input logic ready, input logic error,
                                            input logic go, input logic rstreq);
    logic [31:0] w;
    w              = 32'h0000_0000;
    w[CTRL_READY]  = ready;
    w[CTRL_ERROR]  = error;
    w[CTRL_GO]     = go;
    w[CTRL_RSTREQ] = rstreq;
    return w;
  endfunction

endpackage

// File: rtl/asphalt_debug_ocimem_ram.sv
// Single-port debug monitor RAM: DEPTH x 32, byte-enable write, registered read.
module asphalt_debug_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem_r [DEPTH];

  // One access per cycle: masked byte write, or a read registered into rdata.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int bi = 0; bi < 4; bi++) begin
          if (be[bi]) begin
            mem_r[addr][8*bi +: 8] <= wdata[8*bi +: 8];
          end
        end
      end else begin
        rdata <= mem_r[addr];
      end
    end
  end

endmodule

// File: rtl/asphalt_debug_ocimem.sv
// Debug monitor memory: JTAG command consumer, monitor RAM arbitration between
// the debugger and the CPU's Avalon debug slave, and the monitor handshake flags.
module asphalt_debug_ocimem
  import asphalt_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter bit INIT_GO = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              monitor_go,
  output logic              resetrequest
);

  av_state_e         state_r, state_nx_s;
  logic              rd_ctrl_r;
  logic              jtag_pend_r, jtag_wr_r, jtag_rd_valid_r;
  logic [31:0]       jtag_wdata_r;
  logic [ADDR_W-1:0] mon_a_r;

  logic              act_a_s, act_na_s, act_b_s;
  logic              av_rd_go_s, av_wr_go_s, ctrl_wr_s;
  logic              ram_en_s, ram_we_s;
  logic [3:0]        ram_be_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [31:0]       ram_wdata_s, ram_rdata_s;
  logic              unused_s;

  // Payload bits outside any command field.
  assign unused_s = ^{jdo[37:35], jdo[2:0]};

  // Resolve strobe priority: action_b, then action_a, then no_action_a.
  always_comb begin
    act_b_s  = take_action_ocimem_b;
    act_a_s  = take_action_ocimem_a & ~take_action_ocimem_b;
    act_na_s = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  end

  // Avalon next state, stall and RAM port arbitration (pending JTAG op first).
  always_comb begin
    state_nx_s      = state_r;
    av_rd_go_s      = 1'b0;
    av_wr_go_s      = 1'b0;
    avs_waitrequest = 1'b0;
    ram_en_s        = 1'b0;
    ram_we_s        = 1'b0;
    ram_be_s        = 4'h0;
    ram_addr_s      = mon_a_r;
    ram_wdata_s     = jtag_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (!reset_n) begin
          state_nx_s = ST_IDLE;
        end else if (jtag_pend_r) begin
          avs_waitrequest = avs_read | avs_write;
        end else if (avs_read) begin
          av_rd_go_s      = 1'b1;
          avs_waitrequest = 1'b1;
          state_nx_s      = ST_RD_WAIT;
        end else if (avs_write) begin
          av_wr_go_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: state_nx_s = ST_IDLE;
      default:    state_nx_s = ST_IDLE;
    endcase
    if (jtag_pend_r) begin
      ram_en_s = 1'b1;
      ram_we_s = jtag_wr_r;
      ram_be_s = 4'hF;
    end else if ((av_rd_go_s | av_wr_go_s) & ~avs_address[ADDR_W]) begin
      ram_en_s    = 1'b1;
      ram_we_s    = av_wr_go_s;
      ram_be_s    = avs_byteenable;
      ram_addr_s  = avs_address[ADDR_W-1:0];
      ram_wdata_s = avs_writedata;
    end else begin
      ram_en_s = 1'b0;
    end
    ctrl_wr_s = av_wr_go_s & avs_address[ADDR_W];
  end

  // Avalon state register and the read-target latch (RAM or control register).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      rd_ctrl_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (av_rd_go_s) begin
        rd_ctrl_r <= avs_address[ADDR_W];
      end
    end
  end

  // Capture Avalon read data in the wait state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= 32'h0000_0000;
    end else if (state_r == ST_RD_WAIT) begin
      avs_readdata <= rd_ctrl_r ? ctrl_word(monitor_ready, monitor_error, monitor_go, resetrequest)
                                : ram_rdata_s;
    end
  end

  // Single-entry JTAG op slot; a new strobe replaces whatever is queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jtag_pend_r     <= 1'b0;
      jtag_wr_r       <= 1'b0;
      jtag_wdata_r    <= 32'h0000_0000;
      jtag_rd_valid_r <= 1'b0;
    end else begin
      jtag_rd_valid_r <= jtag_pend_r & ~jtag_wr_r;
      if (act_b_s) begin
        jtag_pend_r  <= 1'b1;
        jtag_wr_r    <= 1'b1;
        jtag_wdata_r <= jdo[JDO_DATA_LSB +: 32];
      end else if (act_a_s | act_na_s) begin
        jtag_pend_r <= 1'b1;
        jtag_wr_r   <= 1'b0;
      end else begin
        jtag_pend_r <= 1'b0;
      end
    end
  end

  // MonAReg: loaded by action_a, post-incremented (wrapping) when a JTAG write issues.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a_r <= '0;
    end else if (act_a_s) begin
      mon_a_r <= jdo[JDO_ADDR_LSB +: ADDR_W];
    end else if (jtag_pend_r & jtag_wr_r) begin
      mon_a_r <= mon_a_r + ADDR_W'(1);
    end
  end

  // MonDReg: write payload from action_b, otherwise RAM data of a finished JTAG read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MonDReg <= 32'h0000_0000;
    end else if (act_b_s) begin
      MonDReg <= jdo[JDO_DATA_LSB +: 32];
    end else if (jtag_rd_valid_r) begin
      MonDReg <= ram_rdata_s;
    end
  end

  // Handshake flags; a CPU control write wins over a same-cycle debugger update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      monitor_go    <= INIT_GO;
      resetrequest  <= 1'b0;
    end else begin
      if (act_a_s) begin
        resetrequest <= jdo[JDO_RSTREQ];
      end
      if (ctrl_wr_s & avs_writedata[CTRL_READY]) begin
        monitor_ready <= 1'b1;
      end else if (act_a_s & jdo[JDO_GO]) begin
        monitor_ready <= 1'b0;
      end
      if (ctrl_wr_s & avs_writedata[CTRL_ERROR]) begin
        monitor_error <= 1'b1;
      end else if (act_a_s & jdo[JDO_CLRERR]) begin
        monitor_error <= 1'b0;
      end
      if (ctrl_wr_s & (avs_writedata[CTRL_READY] | avs_writedata[CTRL_GO])) begin
        monitor_go <= 1'b0;
      end else if (act_a_s & jdo[JDO_GO]) begin
        monitor_go <= 1'b1;
      end
    end
  end

  asphalt_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en_s),
    .we    (ram_we_s),
    .be    (ram_be_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

endmodule
